// File: rtl/qk_score_engine_pkg.sv
// Shared types and constants for the QK^T score engine.
//   state_t            : engine FSM encoding (IDLE / COMPUTE / DONE)
//   DEF_*              : default build parameters
//   ACC_W              : dot-product accumulator width for the default build
//   SAT_MAX / SAT_MIN  : saturation bounds for the default element width
//   MASK_VAL           : value written into causally masked score positions
package qk_score_engine_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TOKEN_DIM  = 4;
    localparam int DEF_TOKEN_NUM  = 8;
    localparam int DEF_SHIFT_W    = 5;

    // Wide enough that the sum of TOKEN_DIM full-range products cannot wrap.
    function automatic int acc_width(input int data_width, input int token_dim);
        return 2 * data_width + $clog2(token_dim);
    endfunction

    localparam int ACC_W = acc_width(DEF_DATA_WIDTH, DEF_TOKEN_DIM);

    localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
    localparam logic [DEF_DATA_WIDTH-1:0] MASK_VAL = SAT_MIN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/qk_score_engine_if.sv
// Block-level handshake bundle for the QK^T score engine.
//   Input side : in_valid / in_ready, Q_in, K_in, V_in, cfg_shift, cfg_causal
//   Output side: out_valid / out_ready, A_out, V_out
// master = producer/consumer environment, slave = engine.
interface qk_score_engine_if
    import qk_score_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
    parameter int TOKEN_NUM  = DEF_TOKEN_NUM,
    parameter int SHIFT_W    = DEF_SHIFT_W
);
    localparam int BLK_W = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
    localparam int A_W   = DATA_WIDTH * TOKEN_NUM * TOKEN_NUM;

    logic               in_valid;
    logic               in_ready;
    logic [BLK_W-1:0]   Q_in;
    logic [BLK_W-1:0]   K_in;
    logic [BLK_W-1:0]   V_in;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               cfg_causal;
    logic               out_valid;
    logic               out_ready;
    logic [A_W-1:0]     A_out;
    logic [BLK_W-1:0]   V_out;

    modport master (
        output in_valid, Q_in, K_in, V_in, cfg_shift, cfg_causal, out_ready,
        input  in_ready, out_valid, A_out, V_out
    );

    modport slave (
        input  in_valid, Q_in, K_in, V_in, cfg_shift, cfg_causal, out_ready,
        output in_ready, out_valid, A_out, V_out
    );

endinterface

// File: rtl/qk_score_engine_dot_row.sv
// qk_dot_row: combinational row of the score matrix.
//   q_row : one Q token (TOKEN_DIM elements)
//   k_all : all K tokens
//   shift : arithmetic right shift applied to each raw dot product
//   elem  : TOKEN_NUM scaled, saturated scores Q_row . K_j
module qk_dot_row
    import qk_score_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
    parameter int TOKEN_NUM  = DEF_TOKEN_NUM,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic [TOKEN_DIM-1:0][DATA_WIDTH-1:0]                q_row,
    input  logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] k_all,
    input  logic [SHIFT_W-1:0]                                  shift,
    output logic [TOKEN_NUM-1:0][DATA_WIDTH-1:0]                elem
);
    localparam int AW = acc_width(DATA_WIDTH, TOKEN_DIM);
    localparam logic [DATA_WIDTH-1:0] E_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] E_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [AW-1:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {{(AW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    for (genvar j = 0; j < TOKEN_NUM; j++) begin : g_col
        logic signed [AW-1:0]         acc;
        logic signed [AW-1:0]         scaled;
        logic [AW-DATA_WIDTH:0]       hi;
        logic [DATA_WIDTH-1:0]        res;

        always_comb begin
            acc = '0;
            for (int d = 0; d < TOKEN_DIM; d++) begin
                acc = acc + sext(q_row[d]) * sext(k_all[j][d]);
            end
            scaled = acc >>> shift;
            // Fits in DATA_WIDTH iff every bit above the result's sign bit matches it.
            hi = scaled[AW-1:DATA_WIDTH-1];
            if ((&hi) || (~|hi)) begin
                res = scaled[DATA_WIDTH-1:0];
            end else if (scaled[AW-1]) begin
                res = E_MIN;
            end else begin
                res = E_MAX;
            end
        end

        assign elem[j] = res;
    end

endmodule

// File: rtl/qk_score_engine.sv
// qk_score_engine: sequential QK^T score stage.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave side of qk_score_engine_if
//               - accepts one Q/K/V block + cfg per in_valid/in_ready
//               - produces A = Q*K^T (one row per cycle) and forwards V
//               - holds A_out/V_out with out_valid until out_ready
module qk_score_engine
    import qk_score_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
    parameter int TOKEN_NUM  = DEF_TOKEN_NUM,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input logic               clk,
    input logic               rst,
    qk_score_engine_if.slave  bus
);
    localparam int ROW_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(TOKEN_NUM - 1);
    localparam logic [DATA_WIDTH-1:0] MASK_E   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                                              state;
    logic [ROW_W-1:0]                                    row;
    logic                                                in_ready_q;
    logic                                                out_valid_q;
    logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] q_q;
    logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] k_q;
    logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] v_q;
    logic [SHIFT_W-1:0]                                  shift_q;
    logic                                                causal_q;
    logic [TOKEN_NUM-1:0][TOKEN_NUM-1:0][DATA_WIDTH-1:0] a_q;
    logic [TOKEN_NUM-1:0][DATA_WIDTH-1:0]                dot;

    // Single dot-product row, time-shared across all rows of the block.
    qk_dot_row #(
        .DATA_WIDTH (DATA_WIDTH),
        .TOKEN_DIM  (TOKEN_DIM),
        .TOKEN_NUM  (TOKEN_NUM),
        .SHIFT_W    (SHIFT_W)
    ) u_dot_row (
        .q_row (q_q[row]),
        .k_all (k_q),
        .shift (shift_q),
        .elem  (dot)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.A_out     = a_q;
    assign bus.V_out     = v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            k_q         <= '0;
            v_q         <= '0;
            shift_q     <= '0;
            causal_q    <= 1'b0;
            a_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        q_q        <= bus.Q_in;
                        k_q        <= bus.K_in;
                        v_q        <= bus.V_in;
                        shift_q    <= bus.cfg_shift;
                        causal_q   <= bus.cfg_causal;
                        row        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < TOKEN_NUM; j++) begin
                        // Future tokens are forced to the most-negative score so
                        // softmax drives them to zero weight.
                        if (causal_q && (j > int'(row))) begin
                            a_q[row][j] <= MASK_E;
                        end else begin
                            a_q[row][j] <= dot[j];
                        end
                    end
                    if (row == ROW_LAST) begin
                        row         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    row         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qk_score_engine.sv
// Directed self-checking bench for qk_score_engine (16-bit, 4-dim, 8 tokens).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_qk_score_engine;
    import qk_score_engine_pkg::*;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int N  = 8;
    localparam int SW = 5;

    typedef logic [N-1:0][D-1:0][W-1:0] blk_t;
    typedef logic [N-1:0][N-1:0][W-1:0] amat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qk_score_engine_if #(.DATA_WIDTH(W), .TOKEN_DIM(D), .TOKEN_NUM(N), .SHIFT_W(SW)) bus ();

    qk_score_engine #(.DATA_WIDTH(W), .TOKEN_DIM(D), .TOKEN_NUM(N), .SHIFT_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    blk_t  q_ones, k_twos, v_ramp, v_alt, blk_zero;
    amat_t a_all8, a_causal, a_zero;

    // Index of the first differing element (row*N+col), -1 if equal. Report aid only.
    function automatic int first_diff(input amat_t a, input amat_t e);
        for (int i = 0; i < N*N; i++)
            if (a[i/N][i%N] !== e[i/N][i%N]) return i;
        return -1;
    endfunction

    task automatic load_block(input blk_t q, input blk_t k, input blk_t v,
                              input logic [SW-1:0] sh, input logic c);
        bus.Q_in       = q;
        bus.K_in       = k;
        bus.V_in       = v;
        bus.cfg_shift  = sh;
        bus.cfg_causal = c;
        bus.in_valid   = 1'b1;
    endtask

    // Present a block, wait (bounded) for acceptance; returns at the negedge after the accept edge.
    task automatic accept_block(input blk_t q, input blk_t k, input blk_t v,
                                input logic [SW-1:0] sh, input logic c, input string name);
        int n;
        load_block(q, k, v, sh, c);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_wait: in_ready got %b exp 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_after_accept: got %b exp 0", name, bus.in_ready);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.out_valid !== 1'b1 && cyc < 30);
    endtask

    task automatic test_reset();
        int cyc;
        amat_t a;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.A_out !== '0 || bus.V_out !== '0) begin
            errors++;
            $display("FAIL reset_initial: in_ready %b out_valid %b A_zero %b V_zero %b exp 1 0 1 1",
                     bus.in_ready, bus.out_valid, bus.A_out == '0, bus.V_out == '0);
        end
        rst = 1'b0;
        // Reset while a finished block is being held under backpressure.
        bus.out_ready = 1'b0;
        accept_block(q_ones, k_twos, v_ramp, 5'd0, 1'b0, "reset_mid");
        wait_valid(cyc);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_valid: out_valid got %b exp 1", bus.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        a = bus.A_out;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || a !== a_zero || bus.V_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_traffic: in_ready %b out_valid %b A_diff %0d V %h exp 1 0 -1 0",
                     bus.in_ready, bus.out_valid, first_diff(a, a_zero), bus.V_out);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        amat_t a;
        accept_block(q_ones, k_twos, v_ramp, 5'd0, 1'b0, "basic");
        wait_valid(cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL basic_latency: cycles got %0d exp 8", cyc);
        end
        a = bus.A_out;
        checks++;
        if (a !== a_all8) begin
            errors++;
            $display("FAIL basic_A: idx %0d got %h exp 0008", first_diff(a, a_all8),
                     a[first_diff(a, a_all8) / N][first_diff(a, a_all8) % N]);
        end
        checks++;
        if (bus.V_out !== v_ramp) begin
            errors++;
            $display("FAIL basic_V: got %h exp %h", bus.V_out, v_ramp);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_one_cycle: out_valid %b in_ready %b exp 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_causal();
        int cyc;
        amat_t a;
        accept_block(q_ones, k_twos, v_ramp, 5'd1, 1'b1, "causal");
        wait_valid(cyc);
        a = bus.A_out;
        checks++;
        if (cyc != 8 || a !== a_causal) begin
            errors++;
            $display("FAIL causal_A: cycles %0d first_diff %0d exp cycles 8 diff -1", cyc, first_diff(a, a_causal));
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int cyc;
        amat_t a, e;
        blk_t q, k;
        // positive overflow
        q = {N*D{16'h7FFF}};
        k = {N*D{16'h7FFF}};
        accept_block(q, k, v_ramp, 5'd2, 1'b0, "sat_pos");
        wait_valid(cyc);
        a = bus.A_out;
        e = {N*N{16'h7FFF}};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sat_pos: first_diff %0d got %h exp 7fff", first_diff(a, e), a[0][0]);
        end
        @(negedge clk);
        // negative overflow
        k = {N*D{16'h8000}};
        accept_block(q, k, v_ramp, 5'd2, 1'b0, "sat_neg");
        wait_valid(cyc);
        a = bus.A_out;
        e = {N*N{16'h8000}};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sat_neg: first_diff %0d got %h exp 8000", first_diff(a, e), a[0][0]);
        end
        @(negedge clk);
        // small signed dot product: 6 - 5 + 0 - 4 = -3
        q = blk_zero;
        k = blk_zero;
        q[0][0] = 16'd3;  q[0][1] = 16'hFFFB; q[0][2] = 16'd0; q[0][3] = 16'd1;
        k[0][0] = 16'd2;  k[0][1] = 16'd1;    k[0][2] = 16'd7; k[0][3] = 16'hFFFC;
        accept_block(q, k, v_ramp, 5'd0, 1'b0, "signed");
        wait_valid(cyc);
        a = bus.A_out;
        e = a_zero;
        e[0][0] = 16'hFFFD;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL signed_dot: A00 got %h exp fffd, first_diff %0d", a[0][0], first_diff(a, e));
        end
        @(negedge clk);
        // -3 >>> 1 rounds toward -inf: -2
        accept_block(q, k, v_ramp, 5'd1, 1'b0, "signed_shift");
        wait_valid(cyc);
        a = bus.A_out;
        e[0][0] = 16'hFFFE;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL signed_shift: A00 got %h exp fffe, first_diff %0d", a[0][0], first_diff(a, e));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        amat_t a;
        bus.out_ready = 1'b0;
        accept_block(q_ones, k_twos, v_ramp, 5'd0, 1'b0, "bp_first");
        wait_valid(cyc);
        // second block is offered while the first is still held
        load_block(q_ones, k_twos, v_alt, 5'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a = bus.A_out;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || a !== a_all8 || bus.V_out !== v_ramp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid %b in_ready %b A_diff %0d V %h exp 1 0 -1 %h",
                         i, bus.out_valid, bus.in_ready, first_diff(a, a_all8), bus.V_out, v_ramp);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid %b in_ready %b exp 0 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready got %b exp 0", bus.in_ready);
        end
        wait_valid(cyc);
        a = bus.A_out;
        checks++;
        if (cyc != 8 || a !== a_causal || bus.V_out !== v_alt) begin
            errors++;
            $display("FAIL bp_second_block: cycles %0d A_diff %0d V %h exp 8 -1 %h",
                     cyc, first_diff(a, a_causal), bus.V_out, v_alt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_compute();
        int cyc;
        int seen;
        amat_t a;
        accept_block(q_ones, k_twos, v_ramp, 5'd0, 1'b0, "rst_compute");
        // rows 0..2 written, row counter now 3
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = bus.A_out;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || a !== a_zero || bus.V_out !== '0) begin
            errors++;
            $display("FAIL rst_compute_state: in_ready %b out_valid %b A_diff %0d V_zero %b exp 1 0 -1 1",
                     bus.in_ready, bus.out_valid, first_diff(a, a_zero), bus.V_out == '0);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_compute_dropped: out_valid cycles got %0d exp 0", seen);
        end
        accept_block(q_ones, k_twos, v_alt, 5'd1, 1'b1, "rst_followup");
        wait_valid(cyc);
        a = bus.A_out;
        checks++;
        if (cyc != 8 || a !== a_causal || bus.V_out !== v_alt) begin
            errors++;
            $display("FAIL rst_followup_block: cycles %0d A_diff %0d exp 8 -1", cyc, first_diff(a, a_causal));
        end
        @(negedge clk);
    endtask

    initial begin
        blk_zero = '0;
        a_zero   = '0;
        q_ones   = {N*D{16'h0001}};
        k_twos   = {N*D{16'h0002}};
        a_all8   = {N*N{16'h0008}};
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < D; d++) begin
                v_ramp[i][d] = 16'(i*D + d + 1);
                v_alt[i][d]  = 16'hA000 + 16'(i*16 + d);
            end
            for (int j = 0; j < N; j++)
                a_causal[i][j] = (j <= i) ? 16'h0004 : 16'h8000;
        end

        bus.in_valid   = 1'b0;
        bus.Q_in       = '0;
        bus.K_in       = '0;
        bus.V_in       = '0;
        bus.cfg_shift  = '0;
        bus.cfg_causal = 1'b0;
        bus.out_ready  = 1'b1;
        rst            = 1'b1;
        repeat (2) @(negedge clk);

        test_reset();
        test_basic();
        test_causal();
        test_saturation();
        test_backpressure();
        test_reset_compute();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
